// File: rtl/window_3x3_gen.sv
// window_3x3_gen
//   Turns a raster stream of 8-bit pixels into registered 3x3 neighbourhoods
//   for the Gaussian blur datapath. Two line buffers hold rows y-1 and y-2.
//   Only full interior windows are flagged, so the output frame is
//   (IMG_W-2) x (IMG_H-2).
//
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   pix_in, pix_valid   input pixel and its qualifier (no backpressure)
//   sof                 start of frame, qualified by pix_valid, marks (0,0)
//   lu..rb              window taps: rows u/c/b = y-2/y-1/y, cols l/c/r
//   win_valid           taps valid this cycle
//   win_cx, win_cy      centre coordinate of the current window
//   frame_done          one-cycle pulse after the last pixel of a frame
module window_3x3_gen #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int X_W   = 10,
  parameter int Y_W   = 9
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [7:0]     pix_in,
  input  logic           pix_valid,
  input  logic           sof,
  output logic [7:0]     lu,
  output logic [7:0]     cu,
  output logic [7:0]     ru,
  output logic [7:0]     lc,
  output logic [7:0]     cc,
  output logic [7:0]     rc,
  output logic [7:0]     lb,
  output logic [7:0]     cb,
  output logic [7:0]     rb,
  output logic           win_valid,
  output logic [X_W-1:0] win_cx,
  output logic [Y_W-1:0] win_cy,
  output logic           frame_done
);

  localparam logic [X_W-1:0] X_LAST = X_W'(IMG_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(IMG_H - 1);

  // Line buffers: lb1 holds row y-1, lb2 holds row y-2. Not reset; their
  // contents only reach a flagged window once two fresh rows have passed.
  logic [7:0] lb1_mem [IMG_W];
  logic [7:0] lb2_mem [IMG_W];

  logic [X_W-1:0] x_q, x_d, x_cur;
  logic [Y_W-1:0] y_q, y_d, y_cur;
  logic           win_valid_q, win_valid_d;
  logic           frame_done_q, frame_done_d;
  logic [X_W-1:0] win_cx_q;
  logic [Y_W-1:0] win_cy_q;
  logic [7:0]     lu_q, cu_q, ru_q, lc_q, cc_q, rc_q, lb_q, cb_q, rb_q;

  // sof overrides the counters so the accepted pixel is (0,0) this cycle.
  always_comb begin
    x_cur = sof ? '0 : x_q;
    y_cur = sof ? '0 : y_q;
  end

  always_comb begin
    x_d          = x_q;
    y_d          = y_q;
    win_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    if (pix_valid) begin
      if (x_cur == X_LAST) begin
        x_d = '0;
        y_d = (y_cur == Y_LAST) ? '0 : y_cur + Y_W'(1);
      end else begin
        x_d = x_cur + X_W'(1);
        y_d = y_cur;
      end
      // x>=2 keeps windows that straddle a line wrap from being flagged.
      win_valid_d  = (x_cur >= X_W'(2)) && (y_cur >= Y_W'(2));
      frame_done_d = (x_cur == X_LAST) && (y_cur == Y_LAST);
    end
  end

  // Read-before-write: the old lb1 entry moves to lb2 as the new pixel lands.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      lb2_mem[x_cur] <= lb1_mem[x_cur];
      lb1_mem[x_cur] <= pix_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q          <= '0;
      y_q          <= '0;
      win_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      win_cx_q     <= '0;
      win_cy_q     <= '0;
      lu_q <= '0; cu_q <= '0; ru_q <= '0;
      lc_q <= '0; cc_q <= '0; rc_q <= '0;
      lb_q <= '0; cb_q <= '0; rb_q <= '0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      win_valid_q  <= win_valid_d;
      frame_done_q <= frame_done_d;
      if (pix_valid) begin
        win_cx_q <= x_cur - X_W'(1);
        win_cy_q <= y_cur - Y_W'(1);
        lu_q <= cu_q;  cu_q <= ru_q;  ru_q <= lb2_mem[x_cur];
        lc_q <= cc_q;  cc_q <= rc_q;  rc_q <= lb1_mem[x_cur];
        lb_q <= cb_q;  cb_q <= rb_q;  rb_q <= pix_in;
      end
    end
  end

  assign lu         = lu_q;
  assign cu         = cu_q;
  assign ru         = ru_q;
  assign lc         = lc_q;
  assign cc         = cc_q;
  assign rc         = rc_q;
  assign lb         = lb_q;
  assign cb         = cb_q;
  assign rb         = rb_q;
  assign win_valid  = win_valid_q;
  assign win_cx     = win_cx_q;
  assign win_cy     = win_cy_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen
//   Directed bench for window_3x3_gen on an 8x6 image with P(x,y)=base+8*y+x.
//   A negedge monitor follows the expected window order and tap values.
module tb_window_3x3_gen;

  localparam int IMG_W = 8;
  localparam int IMG_H = 6;
  localparam int X_W   = 3;
  localparam int Y_W   = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [7:0]     pix_in;
  logic           pix_valid;
  logic           sof;
  logic [7:0]     lu, cu, ru, lc, cc, rc, lb, cb, rb;
  logic           win_valid;
  logic [X_W-1:0] win_cx;
  logic [Y_W-1:0] win_cy;
  logic           frame_done;

  window_3x3_gen #(.IMG_W(IMG_W), .IMG_H(IMG_H), .X_W(X_W), .Y_W(Y_W)) dut (
    .clk(clk), .rst_n(rst_n), .pix_in(pix_in), .pix_valid(pix_valid), .sof(sof),
    .lu(lu), .cu(cu), .ru(ru), .lc(lc), .cc(cc), .rc(rc), .lb(lb), .cb(cb), .rb(rb),
    .win_valid(win_valid), .win_cx(win_cx), .win_cy(win_cy), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic check(input string tag, input int obs, input int expv);
    chk_cnt++;
    if (obs !== expv) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, expv, $time);
    end
  endtask

  // Driver-side annotations of each driven pixel.
  int drv_base = 0;
  bit drv_last = 1'b0;

  // Sampled at the accepting edge.
  int acc_base = 0;
  bit pv_last  = 1'b0;
  bit exp_fd   = 1'b0;
  int sync_gen = 0;

  // Monitor state.
  int seen_gen = 0;
  int exp_cx = 1, exp_cy = 1;
  int win_cnt = 0, fd_cnt = 0;
  int f_lu = -1, f_cc = -1, f_rb = -1, l_lu = -1, l_cc = -1, l_rb = -1;

  initial forever begin
    @(posedge clk);
    pv_last = pix_valid && rst_n;
    exp_fd  = pix_valid && rst_n && drv_last;
    if (!rst_n) sync_gen++;
    else if (pix_valid) begin
      acc_base = drv_base;
      if (sof) sync_gen++;
    end
  end

  initial forever begin
    @(negedge clk);
    if (seen_gen != sync_gen) begin
      seen_gen = sync_gen;
      exp_cx = 1;
      exp_cy = 1;
    end
    check("frame_done", frame_done, exp_fd);
    if (!pv_last) check("idle_quiet", win_valid, 0);
    if (frame_done) fd_cnt++;
    if (win_valid) begin
      logic [7:0] taps [9];
      taps = '{lu, cu, ru, lc, cc, rc, lb, cb, rb};
      win_cnt++;
      check("win_cx", win_cx, exp_cx);
      check("win_cy", win_cy, exp_cy);
      for (int dy = -1; dy <= 1; dy++)
        for (int dx = -1; dx <= 1; dx++)
          check($sformatf("tap(%0d,%0d)@(%0d,%0d)", dx, dy, exp_cx, exp_cy),
                taps[(dy + 1) * 3 + dx + 1],
                acc_base + 8 * (exp_cy + dy) + exp_cx + dx);
      if (exp_cx == 1 && exp_cy == 1) begin f_lu = lu; f_cc = cc; f_rb = rb; end
      if (exp_cx == 6 && exp_cy == 4) begin l_lu = lu; l_cc = cc; l_rb = rb; end
      if (exp_cx == 6) begin
        exp_cx = 1;
        exp_cy = (exp_cy == 4) ? 1 : exp_cy + 1;
      end else exp_cx++;
    end
  end

  task automatic idle(input bit s);
    @(negedge clk);
    pix_valid = 1'b0;
    sof       = s;
    pix_in    = 8'($urandom_range(0, 255));
    drv_last  = 1'b0;
  endtask

  task automatic send_pix(input int v, input bit s, input int b, input bit last);
    @(negedge clk);
    pix_valid = 1'b1;
    pix_in    = 8'(v);
    sof       = s;
    drv_base  = b;
    drv_last  = last;
  endtask

  task automatic send_frame(input int base, input bit with_sof, input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) while ($urandom_range(0, 1) == 1) idle(1'($urandom_range(0, 1)));
      send_pix(base + i, with_sof && i == 0, base, i == IMG_W * IMG_H - 1);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lu"}, lu, 0); check({tag, "_cu"}, cu, 0); check({tag, "_ru"}, ru, 0);
    check({tag, "_lc"}, lc, 0); check({tag, "_cc"}, cc, 0); check({tag, "_rc"}, rc, 0);
    check({tag, "_lb"}, lb, 0); check({tag, "_cb"}, cb, 0); check({tag, "_rb"}, rb, 0);
    check({tag, "_win_valid"}, win_valid, 0);
    check({tag, "_win_cx"}, win_cx, 0);
    check({tag, "_win_cy"}, win_cy, 0);
    check({tag, "_frame_done"}, frame_done, 0);
  endtask

  int w0, d0;

  initial begin
    rst_n = 1'b0; pix_valid = 1'b0; sof = 1'b0; pix_in = 8'd0;
    #13;
    check_all_zero("reset");
    @(negedge clk); #2 rst_n = 1'b1;

    // Plain frame.
    w0 = win_cnt; d0 = fd_cnt;
    send_frame(0, 1'b1, 48, 1'b0);
    repeat (3) idle(1'b0);
    check("p1_windows", win_cnt - w0, 24);
    check("p1_frame_done", fd_cnt - d0, 1);
    check("p1_first_lu", f_lu, 0);
    check("p1_first_cc", f_cc, 9);
    check("p1_first_rb", f_rb, 18);
    check("p1_last_lu", l_lu, 29);
    check("p1_last_cc", l_cc, 38);
    check("p1_last_rb", l_rb, 47);
    $display("frame plain: windows=%0d frame_done=%0d", win_cnt - w0, fd_cnt - d0);

    // Same frame with random gaps, stray sof on idle cycles.
    w0 = win_cnt; d0 = fd_cnt;
    send_frame(0, 1'b1, 48, 1'b1);
    repeat (3) idle(1'b0);
    check("p2_windows", win_cnt - w0, 24);
    check("p2_frame_done", fd_cnt - d0, 1);
    $display("frame gaps: windows=%0d frame_done=%0d", win_cnt - w0, fd_cnt - d0);

    // Back-to-back frames, second offset by 100.
    w0 = win_cnt; d0 = fd_cnt;
    send_frame(0, 1'b1, 48, 1'b0);
    send_frame(100, 1'b1, 48, 1'b0);
    repeat (3) idle(1'b0);
    check("p3_windows", win_cnt - w0, 48);
    check("p3_frame_done", fd_cnt - d0, 2);
    check("p3_first_cc", f_cc, 109);
    check("p3_last_cc", l_cc, 138);
    $display("back-to-back: windows=%0d frame_done=%0d", win_cnt - w0, fd_cnt - d0);

    // Restart at (3,2): one old window (1,1), then a full new frame.
    w0 = win_cnt; d0 = fd_cnt;
    send_frame(0, 1'b1, 19, 1'b0);
    send_frame(50, 1'b1, 48, 1'b0);
    repeat (3) idle(1'b0);
    check("p4_windows", win_cnt - w0, 25);
    check("p4_frame_done", fd_cnt - d0, 1);
    check("p4_first_cc", f_cc, 59);
    $display("restart: windows=%0d frame_done=%0d", win_cnt - w0, fd_cnt - d0);

    // Async reset after (5,3): 10 windows so far, then a full frame without sof.
    w0 = win_cnt; d0 = fd_cnt;
    send_frame(0, 1'b1, 30, 1'b0);
    @(negedge clk); pix_valid = 1'b0; sof = 1'b0;
    check("p5_pre_reset_valid", win_valid, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("p5_async");
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    send_frame(0, 1'b0, 48, 1'b0);
    repeat (3) idle(1'b0);
    check("p5_windows", win_cnt - w0, 34);
    check("p5_frame_done", fd_cnt - d0, 1);
    $display("reset: windows=%0d frame_done=%0d", win_cnt - w0, fd_cnt - d0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
